// File: rtl/pack8to32_pkg.sv
// Shared types and default geometry for the pack8to32 byte-to-word packer.
// Imported by the interface, the lane packer and the top level.
package pack_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_LANES       = 4;
  localparam int DEF_LANE_W      = 8;
  localparam int DEF_ADDR_STRIDE = 4;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/pack8to32_if.sv
// Bundles the control, upstream and downstream handshake signals of pack8to32.
// The master drives the inputs of the packer; the slave modport is the packer itself.
interface pack8to32_if;
  import pack_pkg::*;

  word_t base;
  word_t count;
  logic  _start;
  word_t in_data;
  logic  in_valid;
  logic  in_ready;
  logic  _ready;
  logic  _valid;
  logic  _done;
  word_t _out0;
  word_t _out1;

  modport master (
    output base, count, _start, in_data, in_valid, _ready,
    input  in_ready, _valid, _done, _out0, _out1
  );

  modport slave (
    input  base, count, _start, in_data, in_valid, _ready,
    output in_ready, _valid, _done, _out0, _out1
  );

endinterface

// File: rtl/pack8to32_lane_packer.sv
// Lane insert register plus lane counter: assembles LANES bytes little-endian.
// word shows the assembled value including a byte loaded this cycle; full marks the last lane.
module lane_packer #(
  parameter int LANES  = pack_pkg::DEF_LANES,
  parameter int LANE_W = pack_pkg::DEF_LANE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [LANE_W-1:0]       byte_in,
  output logic [LANES*LANE_W-1:0] word,
  output logic                    full
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]        lane_q, lane_d;
  logic [LANES*LANE_W-1:0] sr_q, sr_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sr_d   = sr_q;
    lane_d = lane_q;
    full   = 1'b0;
    word   = sr_q;
    word[lane_q*LANE_W +: LANE_W] = byte_in;
    if (clr) begin
      sr_d   = '0;
      lane_d = '0;
    end else if (load) begin
      if (lane_q == LAST_LANE) begin
        full   = 1'b1;
        sr_d   = '0;
        lane_d = '0;
      end else begin
        sr_d   = word;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // NOTE: datapath registers are reset too, so a run after reset never sees stale lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      lane_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      sr_q   <= sr_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/pack8to32.sv
// Packs LANES byte samples into one little-endian word and emits count words with addresses,
// followed by a done beat, over a valid/ready/done output handshake.
module pack8to32
  import pack_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int LANE_W      = DEF_LANE_W,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic        _clock,
  input  logic        _reset,
  pack8to32_if.slave  bus
);

  state_t      state_q, state_d;
  logic [31:0] i_q, i_d;
  word_t       count_q, count_d;
  word_t       addr_q, addr_d;
  logic        in_ready_q, in_ready_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  word_t       out0_q, out0_d;
  word_t       out1_q, out1_d;

  logic                    pk_clr;
  logic                    pk_load;
  logic                    pk_full;
  logic [LANES*LANE_W-1:0] pk_word;

  // Only the low LANE_W bits of a sample carry data.
  logic unused_in_hi;
  assign unused_in_hi = ^bus.in_data[WORD_W-1:LANE_W];

  lane_packer #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_packer (
    .clk     (_clock),
    .rst_n   (_reset),
    .clr     (pk_clr),
    .load    (pk_load),
    .byte_in (bus.in_data[LANE_W-1:0]),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    count_d    = count_q;
    addr_d     = addr_q;
    in_ready_d = in_ready_q;
    valid_d    = valid_q;
    done_d     = done_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    pk_clr     = 1'b0;
    pk_load    = 1'b0;

    if (bus._start) begin
      // A start aborts whatever is in flight, including a partial word or a pending beat.
      count_d = bus.count;
      addr_d  = bus.base;
      i_d     = '0;
      pk_clr  = 1'b1;
      valid_d = 1'b0;
      done_d  = 1'b0;
      if (bus.count <= 0) begin
        state_d    = FINISH;
        in_ready_d = 1'b0;
      end else begin
        state_d    = FILL;
        in_ready_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_d = 1'b0;
          if (valid_q && bus._ready) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
          end
        end
        FILL: begin
          pk_load = bus.in_valid && in_ready_q;
          if (pk_full) begin
            out0_d     = word_t'(pk_word);
            out1_d     = addr_q;
            valid_d    = 1'b1;
            in_ready_d = 1'b0;
            state_d    = EMIT;
          end
        end
        EMIT: begin
          if (bus._ready) begin
            i_d     = i_q + 32'd1;
            addr_d  = addr_q + word_t'(ADDR_STRIDE);
            valid_d = 1'b0;
            if ((i_q + 32'd1) == $unsigned(count_q)) begin
              state_d = FINISH;
            end else begin
              state_d    = FILL;
              in_ready_d = 1'b1;
            end
          end
        end
        FINISH: begin
          // First cycle raises the done beat; it retires on the next accepted _ready.
          if (!valid_q) begin
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else if (bus._ready) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus._valid   = valid_q;
  assign bus._done    = done_q;
  assign bus._out0    = out0_q;
  assign bus._out1    = out1_q;

endmodule

// File: tb/tb_pack8to32.sv
// Directed bench for pack8to32: a byte-level reference model fills a beat scoreboard,
// and each beat accepted downstream is popped and compared.
module tb_pack8to32;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        done;
  } beat_t;

  logic clk;
  logic rst_n;

  pack8to32_if bus ();

  pack8to32 dut (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t       sb[$];
  logic [31:0] log_d[$];
  logic [31:0] log_a[$];
  int          log_c[$];

  logic [31:0] m_word, m_addr, m_last_d, m_last_a;
  int          m_lane, m_n, m_count;
  int          cyc_n = 0;
  logic        last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    m_word[8*m_lane +: 8] = b;
    m_lane++;
    if (m_lane == 4) begin
      sb.push_back('{data: m_word, addr: m_addr, done: 1'b0});
      m_last_d = m_word;
      m_last_a = m_addr;
      m_addr   = m_addr + 32'd4;
      m_word   = '0;
      m_lane   = 0;
      m_n++;
      if (m_n == m_count) sb.push_back('{data: m_last_d, addr: m_last_a, done: 1'b1});
    end
  endtask

  // Observe the cycle about to retire with the inputs now driven, then advance one clock.
  task automatic cyc();
    logic  acc;
    logic  beat;
    beat_t e;
    acc  = bus.in_valid && bus.in_ready && !bus._start;
    beat = bus._valid && bus._ready && !bus._start;
    if (bus._valid && !bus._done) check("in_ready_low_emit", bus.in_ready, 1'b0);
    if (beat) begin
      check("beat_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out0", bus._out0, e.data);
        check("out1", bus._out1, e.addr);
        check("done", bus._done, e.done);
      end
      if (!bus._done) begin
        log_d.push_back(bus._out0);
        log_a.push_back(bus._out1);
        log_c.push_back(cyc_n);
      end
    end
    if (acc) model_accept(bus.in_data[7:0]);
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] c, input logic offer);
    bus.base     = b;
    bus.count    = c;
    bus._start   = 1'b1;
    bus.in_valid = offer;
    bus.in_data  = 32'h0000_00EE;
    sb.delete();
    log_d.delete();
    log_a.delete();
    log_c.delete();
    m_word  = '0;
    m_lane  = 0;
    m_addr  = b;
    m_n     = 0;
    m_count = $signed(c);
    if ($signed(c) <= 0) sb.push_back('{data: m_last_d, addr: m_last_a, done: 1'b1});
    cyc();
    bus._start   = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [31:0] d, input int gap);
    int n;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) cyc();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 40);
    check("byte_accepted", last_acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || bus._valid) && n < 60) begin
      cyc();
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    sb.delete();
    m_last_d = '0;
    m_last_a = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    bus.base = '0; bus.count = '0; bus._start = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus._ready = 1'b0;
    m_last_d = '0; m_last_a = '0; m_count = 0; m_n = 0; m_lane = 0;
    m_word = '0; m_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid",    bus._valid,   1'b0);
    check("rst_done",     bus._done,    1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out0",     bus._out0,    32'h0);
    check("rst_out1",     bus._out1,    32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // One word, back-to-back bytes, downstream always ready.
    bus._ready = 1'b1;
    start_run(32'h0000_1000, 32'd1, 1'b0);
    check("t1_in_ready_fill", bus.in_ready, 1'b1);
    send_byte(32'h11, 0);
    send_byte(32'h22, 0);
    send_byte(32'h33, 0);
    send_byte(32'h44, 0);
    check("t1_valid_latency", bus._valid, 1'b1);
    bus.in_valid = 1'b0;
    cyc();
    check("t1_finish_entry_valid", bus._valid, 1'b0);
    cyc();
    check("t1_done_valid", bus._valid, 1'b1);
    check("t1_done_flag",  bus._done,  1'b1);
    drain();
    check("t1_words", log_d.size(), 1);
    check("t1_word0", log_d[0], 32'h4433_2211);
    check("t1_addr0", log_a[0], 32'h0000_1000);
    check("t1_idle_valid", bus._valid, 1'b0);

    // Two words from a repeated sample; LANES+1 cycle period.
    start_run(32'h0, 32'd2, 1'b0);
    for (int k = 0; k < 8; k++) send_byte(32'd42069, 0);
    drain();
    check("t2_words", log_d.size(), 2);
    check("t2_word0", log_d[0], 32'h5555_5555);
    check("t2_word1", log_d[1], 32'h5555_5555);
    check("t2_addr0", log_a[0], 32'h0);
    check("t2_addr1", log_a[1], 32'h4);
    check("t2_period", log_c[1] - log_c[0], 5);

    // count == 0: only a done beat, holding the previous word.
    start_run(32'h0000_0ABC, 32'd0, 1'b1);
    check("t3_in_ready", bus.in_ready, 1'b0);
    check("t3_entry_valid", bus._valid, 1'b0);
    cyc();
    check("t3_done_valid", bus._valid, 1'b1);
    check("t3_done_flag",  bus._done,  1'b1);
    check("t3_in_ready2",  bus.in_ready, 1'b0);
    drain();
    check("t3_words", log_d.size(), 0);

    // Upstream gaps and a 5-cycle downstream stall on word 1.
    start_run(32'h0000_2000, 32'd3, 1'b0);
    for (int k = 0; k < 4; k++) send_byte($urandom_range(0, 255), $urandom_range(0, 2));
    bus.in_valid = 1'b0;
    cyc();
    bus._ready = 1'b0;
    for (int k = 0; k < 4; k++) send_byte($urandom_range(0, 255), $urandom_range(0, 2));
    snap = bus._out0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom_range(0, 255);
      cyc();
      check("t4_stall_valid",    bus._valid,   1'b1);
      check("t4_stall_out0",     bus._out0,    snap);
      check("t4_stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus._ready   = 1'b1;
    for (int k = 0; k < 4; k++) send_byte($urandom_range(0, 255), $urandom_range(0, 2));
    drain();
    check("t4_words", log_d.size(), 3);
    check("t4_addr2", log_a[2], 32'h0000_2008);

    // Reset after two of four bytes, then a clean run.
    start_run(32'h0000_3000, 32'd1, 1'b0);
    send_byte(32'h01, 0);
    send_byte(32'h02, 0);
    apply_reset_now();
    #1;
    check("t5_rst_valid",    bus._valid,   1'b0);
    check("t5_rst_done",     bus._done,    1'b0);
    check("t5_rst_in_ready", bus.in_ready, 1'b0);
    check("t5_rst_out0",     bus._out0,    32'h0);
    check("t5_rst_out1",     bus._out1,    32'h0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    start_run(32'h0000_3000, 32'd1, 1'b0);
    send_byte(32'hAA, 0);
    send_byte(32'hBB, 0);
    send_byte(32'hCC, 0);
    send_byte(32'hDD, 0);
    drain();
    check("t5_words", log_d.size(), 1);
    check("t5_word0", log_d[0], 32'hDDCC_BBAA);

    // Restart mid-FILL onto a wrapping base address.
    start_run(32'h0000_5000, 32'd2, 1'b0);
    send_byte(32'h77, 0);
    send_byte(32'h88, 0);
    start_run(32'hFFFF_FFFC, 32'd2, 1'b1);
    for (int k = 0; k < 8; k++) send_byte(32'h10 + k, 0);
    drain();
    check("t6_words", log_d.size(), 2);
    check("t6_word0", log_d[0], 32'h1312_1110);
    check("t6_word1", log_d[1], 32'h1716_1514);
    check("t6_addr0", log_a[0], 32'hFFFF_FFFC);
    check("t6_addr1", log_a[1], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
